// File: rtl/cell_plot_arbiter.sv
// cell_plot_arbiter
//   Shares the single VGA pixel-write port between two cell drawers.
//   Requester 0 is the cursor datapath. Requester 1 is the board RAM
//   placement/flip path. Arbitration is round-robin and admits one cell at
//   a time. The granted cell is rastered one pixel per clock. A clear pulse
//   repaints all 64 cells as empty, and it takes priority over pending
//   requests.
// Ports
//   clock, resetn        system clock; asynchronous active-low reset
//   clear                one-cycle pulse that requests a full-board repaint
//   req[1:0]             req[i] is held high while requester i has a cell pending
//   cx0/cy0/sel0         requester 0 cell column/row/content
//   cx1/cy1/sel1         requester 1 cell column/row/content
//   gnt[1:0]             one-hot owner, high from LOAD through the owner's last pixel
//   done[1:0]            one-cycle pulse coincident with the owner's last pixel
//   busy                 high in every state except IDLE
//   x, y, colour, plot   registered pixel-write port to vga_adapter
module cell_plot_arbiter #(
  parameter int CELL_SIZE = 14,
  parameter int ORIGIN_X  = 24,
  parameter int ORIGIN_Y  = 4
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        clear,
  input  logic [1:0]  req,
  input  logic [2:0]  cx0,
  input  logic [2:0]  cy0,
  input  logic [1:0]  sel0,
  input  logic [2:0]  cx1,
  input  logic [2:0]  cy1,
  input  logic [1:0]  sel1,
  output logic [1:0]  gnt,
  output logic [1:0]  done,
  output logic        busy,
  output logic [7:0]  x,
  output logic [6:0]  y,
  output logic [17:0] colour,
  output logic        plot
);

  if (CELL_SIZE < 4 || CELL_SIZE > 15 ||
      ORIGIN_X + 8*CELL_SIZE > 160 || ORIGIN_Y + 8*CELL_SIZE > 120) begin : g_param_check
    $error("cell_plot_arbiter: board does not fit the 160x120 frame");
  end

  localparam logic [3:0] LAST = 4'(CELL_SIZE - 1);

  typedef enum logic [2:0] {IDLE, LOAD, DRAW, CLEAR_LOAD, CLEAR_DRAW} state_t;

  state_t     state;
  logic       prio;        // requester that wins when both are requesting
  logic       clear_pend;
  logic       owner;
  logic [5:0] idx;         // clear-pass cell index: {row, column}
  logic [3:0] px, py;
  logic [2:0] cx_l, cy_l;
  logic [1:0] sel_l;

  logic [2:0] ld_cx, ld_cy;
  logic [1:0] ld_sel;
  logic       win;
  logic [3:0] npx, npy;
  logic       last_pix, next_last;

  function automatic logic [7:0] pix_x(input logic [2:0] cx, input logic [3:0] p);
    return 8'(ORIGIN_X) + 8'(cx) * 8'(CELL_SIZE) + 8'(p);
  endfunction

  function automatic logic [6:0] pix_y(input logic [2:0] cy, input logic [3:0] p);
    return 7'(ORIGIN_Y) + 7'(cy) * 7'(CELL_SIZE) + 7'(p);
  endfunction

  // Returns {plot, colour}. A cursor cell paints only its red ring and leaves
  // the interior untouched so the underlying stone remains visible.
  function automatic logic [18:0] shade(input logic [3:0] qx, input logic [3:0] qy,
                                        input logic [1:0] sel);
    logic ring;
    ring = (qx == 4'd0) || (qy == 4'd0) || (qx == LAST) || (qy == LAST);
    if (sel == 2'd3)     return ring ? {1'b1, 18'h3F000} : {1'b0, 18'h00000};
    else if (ring)       return {1'b1, 18'h00000};
    else if (sel == 2'd0) return {1'b1, 18'h00800};
    else if (sel == 2'd1) return {1'b1, 18'h00000};
    else                 return {1'b1, 18'h3FFFF};
  endfunction

  // A single requester always wins. On a tie the preferred requester wins.
  assign win = req[1] & (~req[0] | prio);

  // Operands that are captured while the machine is in LOAD or CLEAR_LOAD.
  always_comb begin
    ld_cx  = owner ? cx1 : cx0;
    ld_cy  = owner ? cy1 : cy0;
    ld_sel = owner ? sel1 : sel0;
    if (state == CLEAR_LOAD) begin
      ld_cx  = idx[2:0];
      ld_cy  = idx[5:3];
      ld_sel = 2'd0;
    end
  end

  assign last_pix  = (px == LAST) && (py == LAST);
  assign npx       = (px == LAST) ? 4'd0 : px + 4'd1;
  assign npy       = (px == LAST) ? py + 4'd1 : py;
  assign next_last = (npx == LAST) && (npy == LAST);
  assign busy      = (state != IDLE);

  always_ff @(posedge clock) begin
    if (state == LOAD || state == CLEAR_LOAD) begin
      cx_l  <= ld_cx;
      cy_l  <= ld_cy;
      sel_l <= ld_sel;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      prio       <= 1'b0;
      clear_pend <= 1'b0;
      owner      <= 1'b0;
      idx        <= '0;
      px         <= '0;
      py         <= '0;
      gnt        <= '0;
      done       <= '0;
      x          <= '0;
      y          <= '0;
      colour     <= '0;
      plot       <= 1'b0;
    end else begin
      done <= '0;
      if (clear) clear_pend <= 1'b1;
      unique case (state)
        IDLE: begin
          plot <= 1'b0;
          gnt  <= '0;
          if (clear_pend || clear) begin
            clear_pend <= 1'b0;
            idx        <= '0;
            state      <= CLEAR_LOAD;
          end else if (|req) begin
            owner <= win;
            gnt   <= win ? 2'b10 : 2'b01;
            state <= LOAD;
          end
        end
        // LOAD / CLEAR_LOAD: capture the operands and present pixel (0,0)
        LOAD, CLEAR_LOAD: begin
          px <= '0;
          py <= '0;
          x  <= pix_x(ld_cx, 4'd0);
          y  <= pix_y(ld_cy, 4'd0);
          {plot, colour} <= shade(4'd0, 4'd0, ld_sel);
          if (state == LOAD) begin
            prio  <= ~owner;
            state <= DRAW;
          end else begin
            state <= CLEAR_DRAW;
          end
        end
        // DRAW / CLEAR_DRAW: one pixel per clock in raster order
        DRAW, CLEAR_DRAW: begin
          if (last_pix) begin
            plot <= 1'b0;
            gnt  <= '0;
            if (state == CLEAR_DRAW && idx != 6'd63) begin
              idx   <= idx + 6'd1;
              state <= CLEAR_LOAD;
            end else begin
              state <= IDLE;
            end
          end else begin
            px <= npx;
            py <= npy;
            x  <= pix_x(cx_l, npx);
            y  <= pix_y(cy_l, npy);
            {plot, colour} <= shade(npx, npy, sel_l);
            if (state == DRAW && next_last) done <= owner ? 2'b10 : 2'b01;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
